riscv_io_bus: RTL and testbench
===============================

Name: riscv_io_bus

Overview:
Parametrised data-bus interconnect between the multicycle RISC-V data port and NUM_SLAVES memory-mapped targets: data BRAM, I/O registers, VGA memory.
- Generalises the fixed two-way "I/O valid vs. data memory" read mux to N address-decoded slaves.
- Adds a per-slave request/acknowledge handshake with wait states, a processor stall output, a timeout watchdog, and bus-error capture.
- Sits between the processor and all data-side slaves in the I/O-system top level.

Parameters:
NUM_SLAVES, 3, number of slave ports (1..8)
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address bus width
SLAVE_BASE, {32'h00008000, 32'h00007f00, 32'h00002000}, packed NUM_SLAVES*ADDR_WIDTH base addresses; slot 0 is the least-significant word
SLAVE_MASK, {32'hFFFF8000, 32'hFFFFFF00, 32'hFFFFE000}, packed match masks; slave i hits when (address & MASK[i]) == BASE[i]
TIMEOUT_CYCLES, 16, wait cycles before abort (>=2)
DEFAULT_READ_DATA, 32'h00000000, read data returned on a decode miss or timeout

Ports:
clk  in  1  single system clock
rst  in  1  synchronous, active-high reset
address  in  ADDR_WIDTH  processor data address
MemRead  in  1  processor read request
MemWrite  in  1  processor write request
dWriteData  in  DATA_WIDTH  processor write data
dReadData  out  DATA_WIDTH  registered read data to processor
read_valid  out  1  one-cycle pulse when dReadData has been updated
bus_stall  out  1  processor must hold its request
s_sel  out  NUM_SLAVES  one-hot slave select
s_read  out  1  read strobe (qualified by s_sel)
s_write  out  1  write strobe (qualified by s_sel)
s_addr  out  ADDR_WIDTH  address to slaves
s_wdata  out  DATA_WIDTH  write data to slaves
s_rdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
s_ack  in  NUM_SLAVES  slave acknowledge
bus_error  out  1  one-cycle pulse on decode miss or timeout
err_addr  out  ADDR_WIDTH  address of the most recent error
err_count  out  8  saturating error counter

Behaviour:
Reset (rst high at a clk edge):
- State goes to IDLE; the wait counter clears.
- dReadData, err_addr and err_count go to 0.
- read_valid, bus_error, s_sel, s_read and s_write go low.
- A reset mid-transaction abandons it; no ack is honoured in the reset cycle.

Request decode:
- A request is MemRead | MemWrite.
- If both are high, the access is a write and the read is ignored.
- Decode is priority-based; the lowest index hit wins on overlap.

State machine:
- IDLE, no request: no strobes, bus_stall = 0.
- IDLE, request with a hit:
  - Drive s_sel[i], s_read/s_write, s_addr = address, s_wdata = dWriteData combinationally in the same cycle.
  - If s_ack[i] is high in that cycle: zero-wait. A read registers s_rdata[i] into dReadData at the edge and pulses read_valid the next cycle. bus_stall = 0 and the state stays IDLE.
  - Otherwise: bus_stall = 1. Latch address, operation, index and write data; go to WAIT with the counter at 1.
- IDLE, request with a miss: no strobes, bus_stall = 0, bus_error pulses the next cycle, err_addr <= address, err_count increments. A read also sets dReadData <= DEFAULT_READ_DATA and pulses read_valid.
- WAIT:
  - Strobes are driven from the latched values; bus_stall = 1; processor input changes are ignored.
  - On s_ack of the latched slave: return to IDLE, bus_stall drops in that same cycle, a read captures data (read_valid next cycle).
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT_CYCLES without an ack: abort. Go to IDLE, apply the miss error actions using the latched address, and release bus_stall in that cycle.
  - Ack and timeout in the same cycle: the ack wins and no error is raised.
- Acks from non-selected slaves are ignored.
- err_count saturates at 255.
- dReadData holds its value between reads; writes never alter it.
- Back-to-back requests are accepted in the IDLE cycle immediately after completion.

Decomposition:
- Package riscv_io_bus_pkg: state enum (IDLE, WAIT), a MAX_SLAVES = 8 constant, and a function that extracts a slot from a packed parameter vector.
- Sub-module riscv_io_addr_decode: combinational priority decoder. Inputs: address and the BASE/MASK vectors. Outputs: hit, index, one-hot select.

Test Plan:
- Zero-wait read: read 0x00002004, slave0 acks the same cycle with 0xDEADBEEF -> bus_stall stays 0, dReadData = 0xDEADBEEF and read_valid = 1 one cycle later.
- Wait states: write 0x00007F10 data 0x1234, slave1 acks after 3 cycles -> s_sel = 3'b010 and s_write held for 4 cycles; bus_stall is high for 3 of them and low on the ack cycle; no bus_error.
- Decode miss: read 0x00004000 -> no s_sel, bus_error pulse, err_addr = 0x00004000, err_count = 1, dReadData = 0.
- Timeout: read 0x00008010, slave2 never acks, TIMEOUT_CYCLES = 16 -> bus_stall high for 16 cycles, then bus_error, err_addr = 0x00008010, dReadData = 0.
- Ack on the timeout cycle: slave2 acks exactly on cycle 16 with 0x55 -> dReadData = 0x55, no bus_error.
- Reset mid-WAIT: rst asserted in cycle 2 of a stalled read -> s_sel = 0 and bus_stall = 0 the next cycle; err_count and dReadData = 0; a subsequent read completes normally.

Source files
------------

// File: rtl/riscv_io_bus_pkg.sv
// Shared types and helpers for the RISC-V data-side bus interconnect.
package riscv_io_bus_pkg;

    localparam int unsigned MAX_SLAVES = 8;
    localparam int unsigned MAX_WIDTH  = 64;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic {
        StIdle,
        StWait
    } bus_state_e;

    // Returns slot idx (width bits, zero-extended) of a packed per-slave vector.
    function automatic logic [MAX_WIDTH-1:0] get_slot(
        input logic [MAX_SLAVES*MAX_WIDTH-1:0] vec,
        input int unsigned                     width,
        input int unsigned                     idx
    );
        logic [MAX_SLAVES*MAX_WIDTH-1:0] shifted;
        logic [MAX_WIDTH-1:0]            slot;
        shifted = vec >> (idx * width);
        slot    = shifted[MAX_WIDTH-1:0];
        for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
            if (b >= width) slot[b] = 1'b0;
        end
        return slot;
    endfunction

endpackage

// File: rtl/riscv_io_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching slot wins.
module riscv_io_addr_decode
    import riscv_io_bus_pkg::*;
#(
    parameter int unsigned                       NUM_SLAVES = 3,
    parameter int unsigned                       ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE =
        {32'h00008000, 32'h00007f00, 32'h00002000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_MASK =
        {32'hFFFF8000, 32'hFFFFFF00, 32'hFFFFE000}
) (
    input  logic [ADDR_WIDTH-1:0] address,
    output logic                  hit,
    output logic [IDX_W-1:0]      index,
    output logic [NUM_SLAVES-1:0] sel
);

    localparam logic [MAX_SLAVES*MAX_WIDTH-1:0] BASE_VEC = (MAX_SLAVES*MAX_WIDTH)'(SLAVE_BASE);
    localparam logic [MAX_SLAVES*MAX_WIDTH-1:0] MASK_VEC = (MAX_SLAVES*MAX_WIDTH)'(SLAVE_MASK);

    always_comb begin
        hit   = 1'b0;
        index = '0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((address & ADDR_WIDTH'(get_slot(MASK_VEC, ADDR_WIDTH, i)))
                         == ADDR_WIDTH'(get_slot(BASE_VEC, ADDR_WIDTH, i)))) begin
                hit    = 1'b1;
                index  = IDX_W'(i);
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_io_bus.sv
// Data-side interconnect: decodes processor accesses onto N slaves with
// ack/wait handshake, processor stall, timeout watchdog and error capture.
module riscv_io_bus
    import riscv_io_bus_pkg::*;
#(
    parameter int unsigned                      NUM_SLAVES        = 3,
    parameter int unsigned                      DATA_WIDTH        = 32,
    parameter int unsigned                      ADDR_WIDTH        = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE        =
        {32'h00008000, 32'h00007f00, 32'h00002000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK        =
        {32'hFFFF8000, 32'hFFFFFF00, 32'hFFFFE000},
    parameter int unsigned                      TIMEOUT_CYCLES    = 16,
    parameter logic [DATA_WIDTH-1:0]            DEFAULT_READ_DATA = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            address,
    input  logic                             MemRead,
    input  logic                             MemWrite,
    input  logic [DATA_WIDTH-1:0]            dWriteData,
    output logic [DATA_WIDTH-1:0]            dReadData,
    output logic                             read_valid,
    output logic                             bus_stall,
    output logic [NUM_SLAVES-1:0]            s_sel,
    output logic                             s_read,
    output logic                             s_write,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_ack,
    output logic                             bus_error,
    output logic [ADDR_WIDTH-1:0]            err_addr,
    output logic [7:0]                       err_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    bus_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   write_q, write_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   err_q, err_d;
    logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
    logic [7:0]             err_count_q, err_count_d;

    logic                   dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic [NUM_SLAVES-1:0]  dec_sel;
    logic [IDX_W-1:0]       cur_idx;
    logic [NUM_SLAVES-1:0]  wait_sel;
    logic [DATA_WIDTH-1:0]  ack_data;
    logic                   req;
    logic                   miss;
    logic                   miss_read;
    logic [ADDR_WIDTH-1:0]  miss_addr;

    assign req     = MemRead | MemWrite;
    assign cur_idx = (state_q == StWait) ? idx_q : dec_idx;

    riscv_io_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .address (address),
        .hit     (dec_hit),
        .index   (dec_idx),
        .sel     (dec_sel)
    );

    always_comb begin
        ack_data = '0;
        wait_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (cur_idx == IDX_W'(i)) ack_data = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            wait_sel[i] = (idx_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        idx_d       = idx_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        bus_stall   = 1'b0;
        s_sel       = '0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_addr      = address;
        s_wdata     = dWriteData;
        miss        = 1'b0;
        miss_read   = 1'b0;
        miss_addr   = address;

        unique case (state_q)
            StIdle: begin
                if (req && dec_hit) begin
                    s_sel   = dec_sel;
                    s_read  = ~MemWrite;
                    s_write = MemWrite;
                    if (|(dec_sel & s_ack)) begin
                        if (!MemWrite) begin
                            rdata_d  = ack_data;
                            rvalid_d = 1'b1;
                        end
                    end else begin
                        bus_stall = 1'b1;
                        addr_d    = address;
                        wdata_d   = dWriteData;
                        write_d   = MemWrite;
                        idx_d     = dec_idx;
                        cnt_d     = CNT_W'(1);
                        state_d   = StWait;
                    end
                end else if (req) begin
                    miss      = 1'b1;
                    miss_read = ~MemWrite;
                end
            end
            StWait: begin
                s_sel   = wait_sel;
                s_read  = ~write_q;
                s_write = write_q;
                s_addr  = addr_q;
                s_wdata = wdata_q;
                // Ack is checked first so it beats a simultaneous timeout.
                if (|(wait_sel & s_ack)) begin
                    state_d = StIdle;
                    if (!write_q) begin
                        rdata_d  = ack_data;
                        rvalid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d   = StIdle;
                    miss      = 1'b1;
                    miss_read = ~write_q;
                    miss_addr = addr_q;
                end else begin
                    bus_stall = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (miss) begin
            err_d      = 1'b1;
            err_addr_d = miss_addr;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            if (miss_read) begin
                rdata_d  = DEFAULT_READ_DATA;
                rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            idx_q       <= idx_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign dReadData  = rdata_q;
    assign read_valid = rvalid_q;
    assign bus_error  = err_q;
    assign err_addr   = err_addr_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_riscv_io_bus.sv
// Self-checking bench for riscv_io_bus: vector table, hand sequences and a
// read-data scoreboard fed at request time and drained on read_valid.
module tb_riscv_io_bus;

    localparam int unsigned NS = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    address;
    logic             MemRead;
    logic             MemWrite;
    logic [DW-1:0]    dWriteData;
    logic [DW-1:0]    dReadData;
    logic             read_valid;
    logic             bus_stall;
    logic [NS-1:0]    s_sel;
    logic             s_read;
    logic             s_write;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0]    s_ack;
    logic             bus_error;
    logic [AW-1:0]    err_addr;
    logic [7:0]       err_count;

    riscv_io_bus #(
        .NUM_SLAVES        (NS),
        .DATA_WIDTH        (DW),
        .ADDR_WIDTH        (AW),
        .SLAVE_BASE        ({32'h00008000, 32'h00007f00, 32'h00002000}),
        .SLAVE_MASK        ({32'hFFFF8000, 32'hFFFFFF00, 32'hFFFFE000}),
        .TIMEOUT_CYCLES    (TO),
        .DEFAULT_READ_DATA (32'h00000000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .dWriteData (dWriteData),
        .dReadData  (dReadData),
        .read_valid (read_valid),
        .bus_stall  (bus_stall),
        .s_sel      (s_sel),
        .s_read     (s_read),
        .s_write    (s_write),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .s_ack      (s_ack),
        .bus_error  (bus_error),
        .err_addr   (err_addr),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rd;
    logic [7:0]    exp_cnt;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NS-1:0] ack;
        logic [DW-1:0] data;
        logic [NS-1:0] e_sel;
        logic          e_read;
        logic          e_write;
        logic          e_err;
        logic          e_push;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Non-acking slots carry distinct junk so a mis-steered read mux shows up.
    task automatic set_rdata(input logic [NS-1:0] ack, input logic [DW-1:0] data);
        for (int i = 0; i < int'(NS); i++) begin
            s_rdata[i*DW +: DW] = ack[i] ? data : (data ^ (32'h11111111 * 32'(i + 1)));
        end
    endtask

    task automatic note_error();
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    endtask

    always @(negedge clk) begin
        if (read_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_valid_unexpected: got pulse with data 0x%0h, expected none",
                         dReadData);
            end else begin
                chk("scoreboard_rdata", 64'(dReadData), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0] = '{1'b1, 1'b0, 32'h00002004, 32'h0,    3'b001, 32'hDEADBEEF,
                    3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h00007F10, 32'hA5A5, 3'b010, 32'h0,
                    3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h00008010, 32'h0,    3'b100, 32'h55AA55AA,
                    3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55AA55AA};
        vecs[3] = '{1'b1, 1'b1, 32'h00002008, 32'hBEEF, 3'b001, 32'hFFFFFFFF,
                    3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h00004000, 32'h0,    3'b000, 32'h0,
                    3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h00002004, 32'h0,    3'b001, 32'h12345678,
                    3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h00007FFF, 32'h0,    3'b010, 32'h13572468,
                    3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13572468};
        vecs[7] = '{1'b1, 1'b0, 32'h00003FFC, 32'h0,    3'b001, 32'h0BADF00D,
                    3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0BADF00D};
        vecs[8] = '{1'b0, 1'b1, 32'hFFFF8000, 32'h1,    3'b111, 32'h0,
                    3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 32'h00007F00, 32'h0,    3'b010, 32'hCAFEBABE,
                    3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE};

        rst        = 1'b1;
        address    = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        dWriteData = '0;
        s_ack      = '0;
        s_rdata    = '0;
        last_rd    = '0;
        exp_cnt    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_rdata", 64'(dReadData), 64'h0);
        chk("reset_read_valid", 64'(read_valid), 64'h0);
        chk("reset_bus_error", 64'(bus_error), 64'h0);
        chk("reset_err_addr", 64'(err_addr), 64'h0);
        chk("reset_err_count", 64'(err_count), 64'h0);
        chk("reset_s_sel", 64'(s_sel), 64'h0);
        chk("reset_stall", 64'(bus_stall), 64'h0);

        // Single-cycle transactions: zero-wait hits, misses and idle cycles.
        for (int v = 0; v < 10; v++) begin
            MemRead    = vecs[v].rd;
            MemWrite   = vecs[v].wr;
            address    = vecs[v].addr;
            dWriteData = vecs[v].wdata;
            s_ack      = vecs[v].ack;
            set_rdata(vecs[v].ack, vecs[v].data);
            if (vecs[v].e_push) begin
                exp_q.push_back(vecs[v].e_data);
                last_rd = vecs[v].e_data;
            end
            if (vecs[v].e_err) note_error();
            #1;
            chk($sformatf("vec%0d_s_sel", v), 64'(s_sel), 64'(vecs[v].e_sel));
            chk($sformatf("vec%0d_s_read", v), 64'(s_read), 64'(vecs[v].e_read));
            chk($sformatf("vec%0d_s_write", v), 64'(s_write), 64'(vecs[v].e_write));
            chk($sformatf("vec%0d_stall", v), 64'(bus_stall), 64'h0);
            if (vecs[v].e_sel != '0) begin
                chk($sformatf("vec%0d_s_addr", v), 64'(s_addr), 64'(vecs[v].addr));
            end
            if (vecs[v].e_write) begin
                chk($sformatf("vec%0d_s_wdata", v), 64'(s_wdata), 64'(vecs[v].wdata));
            end
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_bus_error", v), 64'(bus_error), 64'(vecs[v].e_err));
            chk($sformatf("vec%0d_rdata_hold", v), 64'(dReadData), 64'(last_rd));
            if (vecs[v].e_err) begin
                chk($sformatf("vec%0d_err_addr", v), 64'(err_addr), 64'(vecs[v].addr));
                chk($sformatf("vec%0d_err_count", v), 64'(err_count), 64'(exp_cnt));
            end
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        s_ack    = '0;

        // Wait-state write: slave1 acks on the fourth cycle; a stray slave0 ack
        // and a changed processor address in between must be ignored.
        @(posedge clk);
        #1;
        MemWrite   = 1'b1;
        address    = 32'h00007F10;
        dWriteData = 32'h00001234;
        for (int k = 0; k < 4; k++) begin
            s_ack = (k == 3) ? 3'b010 : ((k == 1) ? 3'b001 : 3'b000);
            set_rdata(s_ack, 32'h77777777);
            if (k == 2) begin
                address    = 32'h00004000;
                dWriteData = 32'h0000FFFF;
            end
            #1;
            chk($sformatf("ws%0d_s_sel", k), 64'(s_sel), 64'(3'b010));
            chk($sformatf("ws%0d_s_write", k), 64'(s_write), 64'h1);
            chk($sformatf("ws%0d_s_read", k), 64'(s_read), 64'h0);
            chk($sformatf("ws%0d_s_addr", k), 64'(s_addr), 64'h00007F10);
            chk($sformatf("ws%0d_s_wdata", k), 64'(s_wdata), 64'h00001234);
            chk($sformatf("ws%0d_stall", k), 64'(bus_stall), (k < 3) ? 64'h1 : 64'h0);
            @(posedge clk);
            #1;
        end
        MemWrite = 1'b0;
        s_ack    = '0;
        address  = '0;
        chk("ws_bus_error", 64'(bus_error), 64'h0);
        chk("ws_rdata_hold", 64'(dReadData), 64'(last_rd));

        // Timeout: slave2 never acks.
        MemRead = 1'b1;
        address = 32'h00008010;
        set_rdata(3'b000, 32'h99999999);
        exp_q.push_back(32'h0);
        last_rd = 32'h0;
        note_error();
        n = 0;
        #1;
        while (bus_stall === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #2;
        end
        chk("to_stall_cycles", 64'(n), 64'(TO));
        chk("to_abort_s_sel", 64'(s_sel), 64'(3'b100));
        MemRead = 1'b0;
        @(posedge clk);
        #1;
        chk("to_bus_error", 64'(bus_error), 64'h1);
        chk("to_err_addr", 64'(err_addr), 64'h00008010);
        chk("to_err_count", 64'(err_count), 64'(exp_cnt));
        chk("to_rdata", 64'(dReadData), 64'h0);

        // Ack arrives exactly on the timeout cycle: the ack wins.
        MemRead = 1'b1;
        address = 32'h00008010;
        n = 0;
        #1;
        while (bus_stall === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #2;
        end
        chk("ackto_stall_cycles", 64'(n), 64'(TO));
        s_ack = 3'b100;
        set_rdata(3'b100, 32'h00000055);
        exp_q.push_back(32'h00000055);
        last_rd = 32'h00000055;
        #1;
        chk("ackto_s_sel", 64'(s_sel), 64'(3'b100));
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        s_ack   = '0;
        chk("ackto_bus_error", 64'(bus_error), 64'h0);
        chk("ackto_err_count", 64'(err_count), 64'(exp_cnt));
        chk("ackto_rdata", 64'(dReadData), 64'h00000055);

        // Error counter saturation with back-to-back missing writes.
        MemWrite = 1'b1;
        address  = 32'h00004000;
        for (int i = 0; i < 260; i++) begin
            @(posedge clk);
            note_error();
        end
        #1;
        MemWrite = 1'b0;
        chk("sat_err_count", 64'(err_count), 64'(exp_cnt));
        chk("sat_err_count_max", 64'(err_count), 64'hFF);
        chk("sat_rdata_hold", 64'(dReadData), 64'(last_rd));

        // Reset in the second cycle of a stalled read; the reset-cycle ack is dropped.
        @(posedge clk);
        #1;
        MemRead = 1'b1;
        address = 32'h00002004;
        s_ack   = '0;
        #1;
        chk("rstw_first_stall", 64'(bus_stall), 64'h1);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        MemRead = 1'b0;
        s_ack   = 3'b001;
        set_rdata(3'b001, 32'h00000BAD);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_ack   = '0;
        exp_cnt = '0;
        last_rd = '0;
        #1;
        chk("rstw_s_sel", 64'(s_sel), 64'h0);
        chk("rstw_stall", 64'(bus_stall), 64'h0);
        chk("rstw_err_count", 64'(err_count), 64'h0);
        chk("rstw_rdata", 64'(dReadData), 64'h0);
        chk("rstw_read_valid", 64'(read_valid), 64'h0);

        MemRead = 1'b1;
        address = 32'h00002004;
        s_ack   = 3'b001;
        set_rdata(3'b001, 32'hCAFEF00D);
        exp_q.push_back(32'hCAFEF00D);
        last_rd = 32'hCAFEF00D;
        #1;
        chk("post_rst_stall", 64'(bus_stall), 64'h0);
        chk("post_rst_s_sel", 64'(s_sel), 64'(3'b001));
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        s_ack   = '0;
        chk("post_rst_rdata", 64'(dReadData), 64'hCAFEF00D);
        chk("post_rst_bus_error", 64'(bus_error), 64'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
